// File: rtl/pipe_sched.sv
// Pipeline scheduler: load-use stalls, branch redirect, ERET and interrupt entry.
// Optional build macro PIPE_SCHED_EXT_INT_EN enables external interrupt acceptance;
// without it the external interrupt ports are present but ignored.
module pipe_sched #(
  parameter logic [15:0] INT_VECTOR   = 16'h0008,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        schi_pause_request,
  input  logic        schi_branch,
  input  logic [15:0] schi_new_pc,
  input  logic [15:0] schi_id_addr,
  input  logic        schi_int,
  input  logic [3:0]  schi_int_id,
  input  logic        schi_int_enable,
  input  logic        schi_int_disable,
  input  logic        schi_ext_int,
  input  logic [3:0]  schi_ext_int_id,
  output logic        scho_pc_stall,
  output logic        scho_ifid_stall,
  output logic        scho_ifid_flush,
  output logic        scho_idex_flush,
  output logic        scho_pc_load,
  output logic [15:0] scho_new_pc,
  output logic [15:0] scho_epc,
  output logic [7:0]  scho_cause,
  output logic        scho_int_en
);

  typedef enum logic [1:0] {StIdle, StDrain, StRedirect} state_e;

  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);
  localparam logic [3:0] EretId    = 4'hf;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] epc_q, epc_d;
  logic [7:0]  cause_q, cause_d;
  logic        int_en_q, int_en_d;

  logic is_eret, is_swint, ext_take;

  assign is_eret  = schi_int & (schi_int_id == EretId);
  assign is_swint = schi_int & (schi_int_id != EretId);

`ifdef PIPE_SCHED_EXT_INT_EN
  // External requests wait while a branch is in decode so the delay-slot pair stays together.
  assign ext_take = schi_ext_int & int_en_q & ~schi_branch;
`else
  logic unused_ext;
  assign unused_ext = ^{schi_ext_int, schi_ext_int_id};
  assign ext_take   = 1'b0;
`endif

  // Next-state and output decode; IDLE arbitrates one event per cycle by priority.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    epc_d           = epc_q;
    cause_d         = cause_q;
    int_en_d        = int_en_q;
    scho_pc_stall   = 1'b0;
    scho_ifid_stall = 1'b0;
    scho_ifid_flush = 1'b0;
    scho_idex_flush = 1'b0;
    scho_pc_load    = 1'b0;
    scho_new_pc     = 16'h0000;

    unique case (state_q)
      StIdle: begin
        // Enable/disable pulses; an event below that writes int_en overrides these.
        if (schi_int_enable && !schi_int_disable) begin
          int_en_d = 1'b1;
        end else if (schi_int_disable && !schi_int_enable) begin
          int_en_d = 1'b0;
        end

        if (schi_pause_request) begin
          scho_pc_stall   = 1'b1;
          scho_ifid_stall = 1'b1;
          scho_idex_flush = 1'b1;
        end else if (is_eret) begin
          scho_pc_load    = 1'b1;
          scho_new_pc     = epc_q;
          scho_ifid_flush = 1'b1;
          int_en_d        = 1'b1;
        end else if (is_swint) begin
          scho_pc_stall   = 1'b1;
          scho_ifid_stall = 1'b1;
          scho_idex_flush = 1'b1;
          // Software INT returns past itself.
          epc_d           = schi_id_addr + 16'd1;
          cause_d         = {4'h0, schi_int_id};
          int_en_d        = 1'b0;
          cnt_d           = DrainInit;
          state_d         = StDrain;
        end else if (ext_take) begin
          scho_pc_stall   = 1'b1;
          scho_ifid_stall = 1'b1;
          scho_idex_flush = 1'b1;
          // Interrupted decode instruction is re-executed on return.
          epc_d           = schi_id_addr;
          cause_d         = {1'b1, 3'b000, schi_ext_int_id};
          int_en_d        = 1'b0;
          cnt_d           = DrainInit;
          state_d         = StDrain;
        end else if (schi_branch) begin
          // No flush: the delay slot executes.
          scho_pc_load = 1'b1;
          scho_new_pc  = schi_new_pc;
        end
      end

      StDrain: begin
        scho_pc_stall   = 1'b1;
        scho_ifid_stall = 1'b1;
        scho_idex_flush = 1'b1;
        if (cnt_q == 3'd0) begin
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StRedirect: begin
        scho_pc_load    = 1'b1;
        scho_new_pc     = INT_VECTOR;
        scho_ifid_flush = 1'b1;
        scho_idex_flush = 1'b1;
        state_d         = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset silences every combinational control regardless of state.
    if (rst) begin
      scho_pc_stall   = 1'b0;
      scho_ifid_stall = 1'b0;
      scho_ifid_flush = 1'b0;
      scho_idex_flush = 1'b0;
      scho_pc_load    = 1'b0;
      scho_new_pc     = 16'h0000;
    end
  end

  // State, drain counter and interrupt context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      epc_q    <= 16'h0000;
      cause_q  <= 8'h00;
      int_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      int_en_q <= int_en_d;
    end
  end

  assign scho_epc    = epc_q;
  assign scho_cause  = cause_q;
  assign scho_int_en = int_en_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Testbench for pipe_sched: vector table plus hand sequences, scoreboard-compared.
module tb_pipe_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        schi_pause_request, schi_branch;
  logic [15:0] schi_new_pc, schi_id_addr;
  logic        schi_int;
  logic [3:0]  schi_int_id;
  logic        schi_int_enable, schi_int_disable;
  logic        schi_ext_int;
  logic [3:0]  schi_ext_int_id;
  logic        scho_pc_stall, scho_ifid_stall, scho_ifid_flush, scho_idex_flush, scho_pc_load;
  logic [15:0] scho_new_pc, scho_epc;
  logic [7:0]  scho_cause;
  logic        scho_int_en;

  pipe_sched dut (
    .clk                (clk),
    .rst                (rst),
    .schi_pause_request (schi_pause_request),
    .schi_branch        (schi_branch),
    .schi_new_pc        (schi_new_pc),
    .schi_id_addr       (schi_id_addr),
    .schi_int           (schi_int),
    .schi_int_id        (schi_int_id),
    .schi_int_enable    (schi_int_enable),
    .schi_int_disable   (schi_int_disable),
    .schi_ext_int       (schi_ext_int),
    .schi_ext_int_id    (schi_ext_int_id),
    .scho_pc_stall      (scho_pc_stall),
    .scho_ifid_stall    (scho_ifid_stall),
    .scho_ifid_flush    (scho_ifid_flush),
    .scho_idex_flush    (scho_idex_flush),
    .scho_pc_load       (scho_pc_load),
    .scho_new_pc        (scho_new_pc),
    .scho_epc           (scho_epc),
    .scho_cause         (scho_cause),
    .scho_int_en        (scho_int_en)
  );

  always #5 clk = ~clk;

  // ctl = {pc_stall, ifid_stall, ifid_flush, idex_flush, pc_load}
  localparam logic [4:0] CNone  = 5'b00000;
  localparam logic [4:0] CTriad = 5'b11010;
  localparam logic [4:0] CLoad  = 5'b00001;
  localparam logic [4:0] CEret  = 5'b00101;
  localparam logic [4:0] CRedir = 5'b00111;

  typedef struct {
    logic        r, p, b;
    logic [15:0] npc, ida;
    logic        i;
    logic [3:0]  iid;
    logic        en, dis, ext;
    logic [3:0]  eid;
    logic [4:0]  ctl;
    logic [15:0] enpc, eepc;
    logic [7:0]  ecause;
    logic        eie;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic r, p, b, input logic [15:0] npc, ida,
                              input logic i, input logic [3:0] iid,
                              input logic en, dis, ext, input logic [3:0] eid,
                              input logic [4:0] ctl, input logic [15:0] enpc, eepc,
                              input logic [7:0] ecause, input logic eie);
    vec_t v;
    v.r = r; v.p = p; v.b = b; v.npc = npc; v.ida = ida; v.i = i; v.iid = iid;
    v.en = en; v.dis = dis; v.ext = ext; v.eid = eid; v.ctl = ctl; v.enpc = enpc;
    v.eepc = eepc; v.ecause = ecause; v.eie = eie;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s actual=%h expected=%h", step_no, name, act, exp);
    end
  endtask

  // Drive one cycle at posedge+1, sample controls before the next edge, regs after it.
  task automatic apply(input vec_t v);
    vec_t        e;
    logic [4:0]  ctl;
    logic [15:0] npc;
    rst = v.r; schi_pause_request = v.p; schi_branch = v.b; schi_new_pc = v.npc;
    schi_id_addr = v.ida; schi_int = v.i; schi_int_id = v.iid; schi_int_enable = v.en;
    schi_int_disable = v.dis; schi_ext_int = v.ext; schi_ext_int_id = v.eid;
    sb.push_back(v);
    #3;
    ctl = {scho_pc_stall, scho_ifid_stall, scho_ifid_flush, scho_idex_flush, scho_pc_load};
    npc = scho_new_pc;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ctl", {11'b0, ctl}, {11'b0, e.ctl});
    chk("new_pc", npc, e.enpc);
    chk("epc", scho_epc, e.eepc);
    chk("cause", {8'b0, scho_cause}, {8'b0, e.ecause});
    chk("int_en", {15'b0, scho_int_en}, {15'b0, e.eie});
    step_no++;
  endtask

  initial begin
    rst = 1'b1; schi_pause_request = 1'b0; schi_branch = 1'b0; schi_new_pc = 16'h0;
    schi_id_addr = 16'h0; schi_int = 1'b0; schi_int_id = 4'h0; schi_int_enable = 1'b0;
    schi_int_disable = 1'b0; schi_ext_int = 1'b0; schi_ext_int_id = 4'h0;

    //            r  p  b  npc       ida       i  iid   en dis ext eid   ctl     enpc      epc       cause  ie
    // Reset with pause/INT pending: controls silent, registers cleared.
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 1, 4'h3, 0, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, 16'h1234, 16'h0010, 0, 4'h0, 0, 0, 0, 4'h0, CLoad, 16'h1234, 16'h0000, 8'h00, 0));
    // Pause + branch + ext INT: only the stall triad.
    tbl.push_back(mk(0, 1, 1, 16'h4321, 16'h0020, 0, 4'h0, 0, 0, 1, 4'h5, CTriad, 16'h0000, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 1, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 1));
    // Enable and disable together: unchanged.
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 1, 1, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 1));
    // Software INT 3 at 0x0100, then three drain cycles with noise on the inputs.
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0100, 1, 4'h3, 0, 0, 0, 4'h0, CTriad, 16'h0000, 16'h0101, 8'h03, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 0, 1, 16'h5555, 16'h0777, 1, 4'hf, 1, 0, 1, 4'h2, CTriad, 16'h0000, 16'h0101, 8'h03, 0));
    end
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 1, 0, 0, 4'h0, CRedir, 16'h0008, 16'h0101, 8'h03, 0));
    // ERET back to 0x0101.
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 4'hf, 0, 0, 0, 4'h0, CEret, 16'h0101, 16'h0101, 8'h03, 1));
    // Ext INT deferred behind a branch.
    tbl.push_back(mk(0, 0, 1, 16'h3000, 16'h01ff, 0, 4'h0, 0, 0, 1, 4'h5, CLoad, 16'h3000, 16'h0101, 8'h03, 1));
`ifdef PIPE_SCHED_EXT_INT_EN
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0200, 0, 4'h0, 0, 0, 1, 4'h5, CTriad, 16'h0000, 16'h0200, 8'h85, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 1, 4'h5, CTriad, 16'h0000, 16'h0200, 8'h85, 0));
    end
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CRedir, 16'h0008, 16'h0200, 8'h85, 0));
`else
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0200, 0, 4'h0, 0, 0, 1, 4'h5, CNone, 16'h0000, 16'h0101, 8'h03, 1));
`endif

    @(posedge clk);
    #1;
    foreach (tbl[n]) apply(tbl[n]);

    // Wrap-around epc, then reset in the second drain cycle: no redirect afterwards.
    apply(mk(0, 0, 0, 16'h0000, 16'hffff, 1, 4'h7, 1, 0, 0, 4'h0, CTriad, 16'h0000, 16'h0000, 8'h07, 0));
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CTriad, 16'h0000, 16'h0000, 8'h07, 0));
    apply(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));

    // Enable/disable pulses, and ERET winning over a simultaneous disable.
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 1, 0, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 1));
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0, 0, 1, 0, 4'h0, CNone, 16'h0000, 16'h0000, 8'h00, 0));
    apply(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 4'hf, 0, 1, 0, 4'h0, CEret, 16'h0000, 16'h0000, 8'h00, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
